pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_pkg.sv | 17 +
 rtl/pe_line_serializer.sv | 90 +++++++++
 rtl/pe_feeder.sv | 163 ++++++++++++++++
 tb/tb_pe_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and FSM encoding for the PE feeder and its line serializer.
package pe_pkg;
  localparam int PE_DATA_W     = 16;
  localparam int PE_LINE_W     = 512;
  localparam int ELEM_PER_LINE = 32;
  localparam int ELEM_IDX_W    = 5;
  localparam int CTL_FIRST     = 0;
  localparam int CTL_LAST      = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INST   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/pe_line_serializer.sv
// Two-slot line buffer for neuron/weight lines; emits one registered element pair per
// cycle, element 0 taken from the MSB end of the line.
module pe_line_serializer
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int LINE_W = PE_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [LINE_W-1:0] wr_nrn,
  input  logic [LINE_W-1:0] wr_wgt,
  input  logic              wr_first,
  input  logic              wr_last,
  input  logic              hold,
  output logic              line_done,
  output logic              empty,
  output logic [DATA_W-1:0] pe_neuron,
  output logic [DATA_W-1:0] pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld
);
  localparam int SEL_W = $clog2(LINE_W);
  localparam logic [ELEM_IDX_W-1:0] LAST_ELEM = ELEM_IDX_W'(ELEM_PER_LINE - 1);

  logic [LINE_W-1:0]     nrn_buf [2];
  logic [LINE_W-1:0]     wgt_buf [2];
  logic [1:0]            full;
  logic [1:0]            first;
  logic [1:0]            last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [ELEM_IDX_W-1:0] elem;
  logic [SEL_W-1:0]      sel_lsb;
  logic                  advance;

  assign advance   = full[rd_ptr] && !hold;
  assign line_done = advance && (elem == LAST_ELEM);
  assign empty     = ~|full;
  assign sel_lsb   = SEL_W'((ELEM_PER_LINE - 1 - int'(elem)) * DATA_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        nrn_buf[s] <= '0;
        wgt_buf[s] <= '0;
      end
      full      <= '0;
      first     <= '0;
      last      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      elem      <= '0;
      pe_neuron <= '0;
      pe_weight <= '0;
      pe_ctl    <= '0;
      pe_vld    <= 1'b0;
    end else begin
      if (advance) begin
        pe_vld              <= 1'b1;
        pe_neuron           <= nrn_buf[rd_ptr][sel_lsb +: DATA_W];
        pe_weight           <= wgt_buf[rd_ptr][sel_lsb +: DATA_W];
        pe_ctl[CTL_FIRST]   <= first[rd_ptr] && (elem == '0);
        pe_ctl[CTL_LAST]    <= last[rd_ptr] && line_done;
        if (line_done) begin
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= ~rd_ptr;
          elem         <= '0;
        end else begin
          elem <= elem + 1'b1;
        end
      end else begin
        pe_vld    <= 1'b0;
        pe_neuron <= '0;
        pe_weight <= '0;
        pe_ctl    <= '0;
      end
      // credits upstream guarantee the write slot is never the one being drained
      if (wr_en) begin
        nrn_buf[wr_ptr] <= wr_nrn;
        wgt_buf[wr_ptr] <= wr_wgt;
        first[wr_ptr]   <= wr_first;
        last[wr_ptr]    <= wr_last;
        full[wr_ptr]    <= 1'b1;
        wr_ptr          <= ~wr_ptr;
      end
    end
  end
endmodule

// File: rtl/pe_feeder.sv
// Fetches a job's instructions, issues paired neuron/weight line reads and feeds the
// PE one element pair per cycle through a double-buffered serializer.
//   state  | meaning
//   IDLE   | waiting for start
//   INST   | fetching instructions, no line requested yet
//   LOAD   | first line requested, waiting for the first beat
//   STREAM | beats flowing, fetch/prefetch continue in background
//   DONE   | one-cycle completion pulse
module pe_feeder
  import pe_pkg::*;
#(
  parameter int DATA_W    = PE_DATA_W,
  parameter int LINE_W    = PE_LINE_W,
  parameter int ADDR_W    = 11,
  parameter int NINST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        num_inst,
  input  logic [ADDR_W-1:0] nrn_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              inst_rd_en,
  output logic [1:0]        inst_rd_addr,
  input  logic [7:0]        inst_rd_data,
  output logic              nrn_rd_en,
  output logic [ADDR_W-1:0] nrn_rd_addr,
  input  logic [LINE_W-1:0] nrn_rd_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [LINE_W-1:0] wgt_rd_data,
  output logic [DATA_W-1:0] pe_neuron,
  output logic [DATA_W-1:0] pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld
);
  state_t            state, state_nxt;
  logic [2:0]        num_q, fetch_idx;
  logic              inst_pend_q, nxt_vld, first_q;
  logic [7:0]        nxt_n, rem;
  logic [1:0]        cred;
  logic [ADDR_W-1:0] nrn_addr_q, wgt_addr_q;
  logic              rd_pend_q, rd_first_q, rd_last_q;
  logic              running, fetch, src_vld, take, issue, cur_first, all_done;
  logic              line_done, sr_empty;
  logic [7:0]        src_n, cur_n;

  always_comb begin
    running   = (state == ST_INST) || (state == ST_LOAD) || (state == ST_STREAM);
    fetch     = running && (fetch_idx < num_q) && !inst_pend_q && !nxt_vld;
    src_vld   = nxt_vld || inst_pend_q;
    src_n     = nxt_vld ? nxt_n : inst_rd_data;
    take      = running && (rem == 8'd0) && src_vld;
    // an instruction arriving with an idle issuer is issued straight away
    cur_n     = (rem != 8'd0) ? rem : (take ? src_n : 8'd0);
    cur_first = (rem == 8'd0) || first_q;
    issue     = running && (cur_n != 8'd0) && (cred != 2'd0);
    all_done  = (fetch_idx == num_q) && !src_vld && (rem == 8'd0) && !rd_pend_q && sr_empty;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (num_inst == 3'd0) ? ST_DONE : ST_INST;
      ST_INST:   if (all_done) state_nxt = ST_DONE;
                 else if (issue) state_nxt = ST_LOAD;
      ST_LOAD:   if (pe_vld) state_nxt = ST_STREAM;
      ST_STREAM: if (all_done) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      num_q       <= '0;
      fetch_idx   <= '0;
      inst_pend_q <= 1'b0;
      nxt_vld     <= 1'b0;
      nxt_n       <= '0;
      rem         <= '0;
      first_q     <= 1'b0;
      cred        <= 2'd2;
      nrn_addr_q  <= '0;
      wgt_addr_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (start) begin
          num_q      <= (num_inst > 3'(NINST_MAX)) ? 3'(NINST_MAX) : num_inst;
          fetch_idx  <= '0;
          nxt_vld    <= 1'b0;
          rem        <= '0;
          first_q    <= 1'b0;
          cred       <= 2'd2;
          nrn_addr_q <= nrn_base;
          wgt_addr_q <= wgt_base;
        end
        inst_pend_q <= 1'b0;
        rd_pend_q   <= 1'b0;
      end else begin
        inst_pend_q <= fetch;
        if (fetch) fetch_idx <= fetch_idx + 3'd1;
        if (inst_pend_q && !take) begin
          nxt_vld <= 1'b1;
          nxt_n   <= inst_rd_data;
        end else if (take) begin
          nxt_vld <= 1'b0;
        end
        if (issue) begin
          rem        <= 8'(cur_n - 8'd1);
          first_q    <= 1'b0;
          nrn_addr_q <= nrn_addr_q + 1'b1;
          wgt_addr_q <= wgt_addr_q + 1'b1;
        end else if (take) begin
          rem     <= src_n;
          first_q <= 1'b1;
        end
        rd_pend_q  <= issue;
        rd_first_q <= cur_first;
        rd_last_q  <= (cur_n == 8'd1);
        if (issue && !line_done) cred <= cred - 2'd1;
        else if (!issue && line_done) cred <= cred + 2'd1;
      end
    end
  end

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign inst_rd_en   = fetch;
  assign inst_rd_addr = fetch_idx[1:0];
  assign nrn_rd_en    = issue;
  assign wgt_rd_en    = issue;
  assign nrn_rd_addr  = nrn_addr_q;
  assign wgt_rd_addr  = wgt_addr_q;

  pe_line_serializer #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rd_pend_q),
    .wr_nrn    (nrn_rd_data),
    .wr_wgt    (wgt_rd_data),
    .wr_first  (rd_first_q),
    .wr_last   (rd_last_q),
    .hold      (hold),
    .line_done (line_done),
    .empty     (sr_empty),
    .pe_neuron (pe_neuron),
    .pe_weight (pe_weight),
    .pe_ctl    (pe_ctl),
    .pe_vld    (pe_vld)
  );
endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: jobs push golden beats into a queue, a negedge
// monitor pops and compares each beat the DUT presents.
module tb_pe_feeder;
  typedef struct packed {
    logic [15:0] n;
    logic [15:0] w;
    logic [1:0]  c;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   num_inst = '0;
  logic [10:0]  nrn_base = '0, wgt_base = '0;
  logic         hold = 1'b0;
  logic         busy, done;
  logic         inst_rd_en;
  logic [1:0]   inst_rd_addr;
  logic [7:0]   inst_rd_data = '0;
  logic         nrn_rd_en, wgt_rd_en;
  logic [10:0]  nrn_rd_addr, wgt_rd_addr;
  logic [511:0] nrn_rd_data = '0, wgt_rd_data = '0;
  logic [15:0]  pe_neuron, pe_weight;
  logic [1:0]   pe_ctl;
  logic         pe_vld;

  int total = 0;
  int bad = 0;
  int bcount = 0;
  int ninst_rd = 0;
  logic [7:0]  inst_mem [4];
  logic [10:0] cur_nb = '0, cur_wb = '0;
  beat_t       exp_q[$];
  logic [10:0] nrd_q[$], wrd_q[$], exp_na[$], exp_wa[$];

  pe_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_inst(num_inst),
    .nrn_base(nrn_base), .wgt_base(wgt_base), .hold(hold),
    .busy(busy), .done(done),
    .inst_rd_en(inst_rd_en), .inst_rd_addr(inst_rd_addr), .inst_rd_data(inst_rd_data),
    .nrn_rd_en(nrn_rd_en), .nrn_rd_addr(nrn_rd_addr), .nrn_rd_data(nrn_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nrn_el(logic [10:0] a, int i);
    return {a, 5'(i)};
  endfunction

  function automatic logic [15:0] wgt_el(logic [10:0] a, int i);
    return {5'(i), a} ^ 16'h5A5A;
  endfunction

  function automatic logic [511:0] make_line(logic [10:0] a, bit w);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 32; i++) l[16*(31-i) +: 16] = w ? wgt_el(a, i) : nrn_el(a, i);
    return l;
  endfunction

  function automatic logic [63:0] outs();
    return {pe_neuron, pe_weight, pe_ctl, pe_vld, busy, done, inst_rd_en, inst_rd_addr,
            nrn_rd_en, nrn_rd_addr, wgt_rd_en, wgt_rd_addr};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // memories with one-cycle read latency
  always @(posedge clk) begin
    if (inst_rd_en) begin
      inst_rd_data <= inst_mem[inst_rd_addr];
      ninst_rd++;
    end
    if (nrn_rd_en) begin
      nrn_rd_data <= make_line(nrn_rd_addr, 1'b0);
      nrd_q.push_back(nrn_rd_addr);
    end
    if (wgt_rd_en) begin
      wgt_rd_data <= make_line(wgt_rd_addr, 1'b1);
      wrd_q.push_back(wgt_rd_addr);
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (pe_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got %0h want none", {pe_neuron, pe_weight, pe_ctl});
      end else begin
        e = exp_q.pop_front();
        check($sformatf("beat%0d", bcount), {pe_neuron, pe_weight, pe_ctl}, e);
      end
      bcount++;
    end else begin
      check("idle_zero", {pe_neuron, pe_weight, pe_ctl}, '0);
    end
    if (nrn_rd_en || wgt_rd_en)
      check("rd_pair", {nrn_rd_en, wgt_rd_en, 11'(nrn_rd_addr - cur_nb)},
            {1'b1, 1'b1, 11'(wgt_rd_addr - cur_wb)});
  end

  task automatic prep_job(input int n, input logic [7:0] i0, i1, i2, i3,
                          input logic [10:0] nb, wb, output int beats, output int lines);
    logic [7:0] iv [4];
    beat_t b;
    iv = '{i0, i1, i2, i3};
    for (int k = 0; k < 4; k++) inst_mem[k] = iv[k];
    beats = 0;
    lines = 0;
    exp_na.delete();
    exp_wa.delete();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < int'(iv[k]); j++) begin
        for (int i = 0; i < 32; i++) begin
          b.n = nrn_el(nb + 11'(lines), i);
          b.w = wgt_el(wb + 11'(lines), i);
          b.c = {(j == int'(iv[k]) - 1) && (i == 31), (j == 0) && (i == 0)};
          exp_q.push_back(b);
          beats++;
        end
        exp_na.push_back(nb + 11'(lines));
        exp_wa.push_back(wb + 11'(lines));
        lines++;
      end
    end
    nrd_q.delete();
    wrd_q.delete();
    ninst_rd = 0;
    cur_nb = nb;
    cur_wb = wb;
  endtask

  task automatic run_job(input string nm, input int n, input logic [7:0] i0, i1, i2, i3,
                         input logic [10:0] nb, wb, input int hold_at);
    int beats, lines, first_c, done_c, vcnt, gaps, hold_left, exp_gaps;
    logic last_vld;
    prep_job(n, i0, i1, i2, i3, nb, wb, beats, lines);
    exp_gaps = (hold_at >= 0) ? 5 : 0;
    @(negedge clk);
    start = 1'b1;
    num_inst = 3'(n);
    nrn_base = nb;
    wgt_base = wb;
    @(posedge clk);
    #1 start = 1'b0;
    first_c = -1; done_c = -1; vcnt = 0; gaps = 0; hold_left = 0; last_vld = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("%s_busy_c%0d", nm, c), busy, 1);
      if (hold_left > 0) begin
        hold_left--;
        check($sformatf("%s_hold_vld", nm), pe_vld, 0);
        if (hold_left == 0) hold = 1'b0;
      end
      if (pe_vld) begin
        if (first_c < 0) first_c = c;
        vcnt++;
        if (vcnt == hold_at + 1) begin
          hold = 1'b1;
          hold_left = 5;
        end
      end else if (first_c >= 0 && !done) begin
        gaps++;
      end
      if (done) begin
        done_c = c;
        check($sformatf("%s_done_after_last_beat", nm), last_vld, beats > 0);
        break;
      end
      last_vld = pe_vld;
    end
    if (done_c < 0) begin
      total++;
      bad++;
      hold = 1'b0;
      $display("FAIL %s_timeout: got no done want done", nm);
      return;
    end
    check($sformatf("%s_beats", nm), vcnt, beats);
    check($sformatf("%s_gaps", nm), gaps, exp_gaps);
    if (n == 0) check($sformatf("%s_done_edge", nm), done_c, 0);
    else if (i0 != 8'd0) begin
      check($sformatf("%s_first_edge", nm), first_c, 4);
      check($sformatf("%s_done_edge", nm), done_c, 4 + beats + exp_gaps);
    end else if (beats > 0) begin
      check($sformatf("%s_done_edge", nm), done_c, first_c + beats + exp_gaps);
    end
    @(posedge clk);
    #1;
    check($sformatf("%s_done_pulse", nm), {done, busy}, 2'b00);
    check($sformatf("%s_left", nm), exp_q.size(), 0);
    check($sformatf("%s_inst_reads", nm), ninst_rd, n);
    check($sformatf("%s_nrn_reads", nm), nrd_q.size(), lines);
    check($sformatf("%s_wgt_reads", nm), wrd_q.size(), lines);
    for (int l = 0; l < lines && l < nrd_q.size() && l < wrd_q.size(); l++) begin
      check($sformatf("%s_naddr%0d", nm, l), nrd_q[l], exp_na[l]);
      check($sformatf("%s_waddr%0d", nm, l), wrd_q[l], exp_wa[l]);
    end
  endtask

  task automatic reset_midjob();
    int beats, lines, v;
    prep_job(1, 8'd2, 8'd0, 8'd0, 8'd0, 11'd7, 11'd3, beats, lines);
    @(negedge clk);
    start = 1'b1;
    num_inst = 3'd1;
    nrn_base = 11'd7;
    wgt_base = 11'd3;
    @(posedge clk);
    #1 start = 1'b0;
    v = 0;
    for (int c = 0; c < 500 && v < 41; c++) begin
      @(posedge clk);
      #1;
      if (pe_vld) v++;
      start = (pe_vld && v == 10);
    end
    start = 1'b0;
    check("rst_reach_beat40", v, 41);
    check("rst_busy_start_ignored", {busy, 32'(ninst_rd)}, {1'b1, 32'd1});
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("rst_outs_immediate", outs(), '0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_outs_held", outs(), '0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_resume", outs(), '0);
    run_job("after_rst", 1, 8'd1, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0, -1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) inst_mem[k] = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", outs(), '0);
    run_job("zero_inst", 0, 8'd5, 8'd5, 8'd5, 8'd5, 11'd0, 11'd0, -1);
    run_job("single", 1, 8'd1, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0, -1);
    run_job("four", 4, 8'd2, 8'd1, 8'd3, 8'd1, 11'd100, 11'd300, -1);
    run_job("skip_zero", 4, 8'd0, 8'd2, 8'd0, 8'd1, 11'd0, 11'd0, -1);
    run_job("hold31", 1, 8'd2, 8'd0, 8'd0, 8'd0, 11'd10, 11'd20, 31);
    run_job("wrap", 1, 8'd3, 8'd0, 8'd0, 8'd0, 11'd2046, 11'd5, -1);
    run_job("all_zero", 3, 8'd0, 8'd0, 8'd0, 8'd0, 11'd9, 11'd9, -1);
    reset_midjob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
